// File: rtl/led_fade_engine_pkg.sv
// Shared constants and state encodings for the LED fade/timing engine.
package led_fade_engine_pkg;

    localparam int unsigned N_DEF    = 6;
    localparam int unsigned T_DEF    = 10;
    localparam int unsigned T1_DEF   = 40;
    localparam int unsigned T2_DEF   = 35;
    localparam int unsigned K_DEF    = 20;
    localparam int unsigned DMAX_DEF = 10;
    localparam int unsigned DUTY_W   = 4;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_COUNT = 2'd1,
        T_DONE  = 2'd2
    } timer_state_t;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_UP   = 2'd1,
        C_HOLD = 2'd2,
        C_DOWN = 2'd3
    } ctrl_state_t;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/led_fade_engine_pwm.sv
// Free-running PWM generator; duty is sampled only at the period boundary.
module pwm_wave_gen
    import led_fade_engine_pkg::*;
#(
    parameter int unsigned T = T_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm_out
);

    localparam int unsigned PCW  = (T > 1) ? $clog2(T) : 1;
    localparam int unsigned CMPW = (PCW > DUTY_W) ? PCW : DUTY_W;

    logic [PCW-1:0]    pc;
    logic [PCW-1:0]    pc_nxt;
    logic [DUTY_W-1:0] duty_q;
    logic [DUTY_W-1:0] duty_nxt;
    logic              pwm_nxt;
    logic              wrap;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc      <= '0;
            duty_q  <= '0;
            pwm_out <= 1'b0;
        end else begin
            pc      <= pc_nxt;
            duty_q  <= duty_nxt;
            pwm_out <= pwm_nxt;
        end
    end

    // pwm_out is computed from next-state values so it lines up with pc/duty_q.
    always_comb begin
        wrap     = (pc == PCW'(T - 1));
        pc_nxt   = wrap ? '0 : pc + PCW'(1);
        duty_nxt = wrap ? duty : duty_q;
        pwm_nxt  = (CMPW'(pc_nxt) < CMPW'(duty_nxt));
    end

endmodule

// File: rtl/led_fade_engine.sv
// Interval timer, brightness ramp controller and PWM output for the LED animator.
module led_fade_engine
    import led_fade_engine_pkg::*;
#(
    parameter int unsigned N    = N_DEF,
    parameter int unsigned T    = T_DEF,
    parameter int unsigned T1   = T1_DEF,
    parameter int unsigned T2   = T2_DEF,
    parameter int unsigned K    = K_DEF,
    parameter int unsigned DMAX = DMAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              timer_clr,
    input  logic              trig,
    input  logic [N-1:0]      load,
    output logic              out_pulse,
    input  logic              start,
    output logic [DUTY_W-1:0] d_c,
    output logic              overflow,
    output logic              pwm_out
);

    localparam int unsigned STEP_MAX = max3(T1, T2, K);
    localparam int unsigned SW       = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;

    timer_state_t      t_state, t_state_nxt;
    logic [N-1:0]      t_count, t_count_nxt;
    logic              out_pulse_nxt;

    ctrl_state_t       c_state, c_state_nxt;
    logic [SW-1:0]     step, step_nxt;
    logic [DUTY_W-1:0] d_c_nxt;
    logic              overflow_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            t_state   <= T_IDLE;
            t_count   <= '0;
            out_pulse <= 1'b0;
        end else begin
            t_state   <= t_state_nxt;
            t_count   <= t_count_nxt;
            out_pulse <= out_pulse_nxt;
        end
    end

    // One-shot timer: pulse after `load` clocks, re-arm only after trig drops.
    always_comb begin
        t_state_nxt   = t_state;
        t_count_nxt   = t_count;
        out_pulse_nxt = 1'b0;
        if (timer_clr) begin
            t_state_nxt = T_IDLE;
            t_count_nxt = '0;
        end else begin
            case (t_state)
                T_IDLE: begin
                    if (trig) begin
                        t_state_nxt = T_COUNT;
                        t_count_nxt = (load == '0) ? N'(1) : load;
                    end
                end
                T_COUNT: begin
                    if (!trig) begin
                        t_state_nxt = T_IDLE;
                        t_count_nxt = '0;
                    end else if (t_count == N'(1)) begin
                        t_state_nxt   = T_DONE;
                        t_count_nxt   = '0;
                        out_pulse_nxt = 1'b1;
                    end else begin
                        t_count_nxt = t_count - N'(1);
                    end
                end
                T_DONE: begin
                    if (!trig) begin
                        t_state_nxt = T_IDLE;
                    end
                end
                default: begin
                    t_state_nxt = T_IDLE;
                    t_count_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            c_state  <= C_IDLE;
            step     <= '0;
            d_c      <= '0;
            overflow <= 1'b0;
        end else begin
            c_state  <= c_state_nxt;
            step     <= step_nxt;
            d_c      <= d_c_nxt;
            overflow <= overflow_nxt;
        end
    end

    // Ramp controller: up every T1, hold K, down every T2, flag the return to zero.
    always_comb begin
        c_state_nxt  = c_state;
        step_nxt     = step;
        d_c_nxt      = d_c;
        overflow_nxt = 1'b0;
        case (c_state)
            C_IDLE: begin
                d_c_nxt = '0;
                if (start) begin
                    c_state_nxt = C_UP;
                    step_nxt    = '0;
                end
            end
            C_UP: begin
                if (step == SW'(T1 - 1)) begin
                    step_nxt = '0;
                    d_c_nxt  = d_c + DUTY_W'(1);
                    if (d_c == DUTY_W'(DMAX - 1)) begin
                        c_state_nxt = C_HOLD;
                    end
                end else begin
                    step_nxt = step + SW'(1);
                end
            end
            C_HOLD: begin
                if (step == SW'(K - 1)) begin
                    step_nxt    = '0;
                    c_state_nxt = C_DOWN;
                end else begin
                    step_nxt = step + SW'(1);
                end
            end
            C_DOWN: begin
                if (step == SW'(T2 - 1)) begin
                    step_nxt = '0;
                    d_c_nxt  = d_c - DUTY_W'(1);
                    if (d_c == DUTY_W'(1)) begin
                        c_state_nxt  = C_IDLE;
                        overflow_nxt = 1'b1;
                    end
                end else begin
                    step_nxt = step + SW'(1);
                end
            end
            default: begin
                c_state_nxt = C_IDLE;
                step_nxt    = '0;
                d_c_nxt     = '0;
            end
        endcase
    end

    pwm_wave_gen #(
        .T(T)
    ) u_pwm (
        .clk    (clk),
        .rst    (rst),
        .duty   (d_c),
        .pwm_out(pwm_out)
    );

endmodule

// File: tb/tb_led_fade_engine.sv
// Directed bench for led_fade_engine plus a standalone pwm_wave_gen for exact duty control.
module tb_led_fade_engine;

    logic       clk;
    logic       rst;
    logic       timer_clr;
    logic       trig;
    logic [5:0] load;
    logic       out_pulse;
    logic       start;
    logic [3:0] d_c;
    logic       overflow;
    logic       pwm_out;
    logic [3:0] pw_duty;
    logic       pwm_sa;

    int n_checks = 0;
    int n_fail   = 0;

    led_fade_engine dut (
        .clk      (clk),
        .rst      (rst),
        .timer_clr(timer_clr),
        .trig     (trig),
        .load     (load),
        .out_pulse(out_pulse),
        .start    (start),
        .d_c      (d_c),
        .overflow (overflow),
        .pwm_out  (pwm_out)
    );

    pwm_wave_gen #(
        .T(10)
    ) u_pwm_sa (
        .clk    (clk),
        .rst    (rst),
        .duty   (pw_duty),
        .pwm_out(pwm_sa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // sel 0 counts out_pulse highs, sel 1 counts standalone pwm highs
    task automatic count_high(input int n, input int sel, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (sel == 0 && out_pulse === 1'b1) cnt++;
            if (sel == 1 && pwm_sa === 1'b1) cnt++;
        end
    endtask

    // Expected duty t clocks after the start edge; restart is sampled at t=771.
    function automatic int exp_dc(input int t);
        if (t < 400) return t / 40;
        if (t <= 420) return 10;
        if (t <= 770) return 10 - (t - 420) / 35;
        return (t - 771) / 40;
    endfunction

    int         cnt;
    int         trace_err;
    int         ov_count;
    int         dc_max;
    int         hi5;
    int         hi10;
    int         lo0;
    int         found;
    logic       prev;
    logic [18:0] got;

    initial begin
        rst       = 1'b0;
        timer_clr = 1'b0;
        trig      = 1'b1;
        start     = 1'b1;
        load      = 6'd10;
        pw_duty   = 4'd0;
        tick(3);
        check("rst_out_pulse", 32'(out_pulse), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_d_c", 32'(d_c), 0);
        check("rst_pwm_out", 32'(pwm_out), 0);
        check("rst_pwm_sa", 32'(pwm_sa), 0);

        // timer arms on the first edge after release
        rst   = 1'b1;
        start = 1'b0;
        tick(1);
        tick(9);
        check("tmr_pre_pulse", 32'(out_pulse), 0);
        tick(1);
        check("tmr_pulse", 32'(out_pulse), 1);
        tick(1);
        check("tmr_pulse_one_cycle", 32'(out_pulse), 0);
        count_high(20, 0, cnt);
        check("tmr_no_repeat", 32'(cnt), 0);

        // drop trig for one clock then re-arm
        trig = 1'b0;
        tick(1);
        trig = 1'b1;
        tick(1);
        tick(9);
        check("tmr2_pre_pulse", 32'(out_pulse), 0);
        tick(1);
        check("tmr2_pulse", 32'(out_pulse), 1);
        tick(1);
        check("tmr2_pulse_end", 32'(out_pulse), 0);

        // abort: trig drops at count 5
        trig = 1'b0;
        tick(1);
        trig = 1'b1;
        tick(1);
        tick(5);
        trig = 1'b0;
        count_high(20, 0, cnt);
        check("tmr_abort", 32'(cnt), 0);

        // clear mid-count, then re-arm after clear releases
        trig = 1'b1;
        tick(1);
        tick(4);
        timer_clr = 1'b1;
        count_high(15, 0, cnt);
        check("tmr_clear", 32'(cnt), 0);
        timer_clr = 1'b0;
        tick(1);
        tick(9);
        check("tmr_rearm_pre", 32'(out_pulse), 0);
        tick(1);
        check("tmr_rearm_pulse", 32'(out_pulse), 1);
        trig = 1'b0;
        tick(2);

        // load=0 behaves as load=1
        load = 6'd0;
        trig = 1'b1;
        tick(1);
        tick(1);
        check("tmr_load0_pulse", 32'(out_pulse), 1);
        tick(1);
        check("tmr_load0_end", 32'(out_pulse), 0);
        trig = 1'b0;
        load = 6'd10;
        tick(2);

        // fade cycle, with an ignored start in UP and a restart on the overflow cycle
        trace_err = 0;
        ov_count  = 0;
        dc_max    = 0;
        hi5       = 0;
        hi10      = 0;
        lo0       = 0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int t = 1; t <= 860; t++) begin
            tick(1);
            if (32'(d_c) !== 32'(exp_dc(t)) || overflow !== (t == 770)) trace_err++;
            if (overflow === 1'b1) ov_count++;
            if (int'(d_c) > dc_max) dc_max = int'(d_c);
            if (t >= 211 && t <= 230 && pwm_out === 1'b1) hi5++;
            if (t >= 415 && t <= 440 && pwm_out === 1'b1) hi10++;
            if (t >= 781 && t <= 810 && pwm_out === 1'b1) lo0++;
            case (t)
                39:  check("fade_t39", 32'(d_c), 0);
                40:  check("fade_t40", 32'(d_c), 1);
                399: check("fade_t399", 32'(d_c), 9);
                400: check("fade_t400", 32'(d_c), 10);
                420: check("fade_hold_end", 32'(d_c), 10);
                454: check("fade_t454", 32'(d_c), 10);
                455: check("fade_first_down", 32'(d_c), 9);
                769: check("fade_t769_ovf", 32'(overflow), 0);
                770: begin
                    check("fade_t770_dc", 32'(d_c), 0);
                    check("fade_t770_ovf", 32'(overflow), 1);
                end
                771: check("fade_t771_ovf", 32'(overflow), 0);
                810: check("restart_t810", 32'(d_c), 0);
                811: check("restart_t811", 32'(d_c), 1);
                default: ;
            endcase
            if (t == 100 || t == 770) start = 1'b1;
            if (t == 101 || t == 771) start = 1'b0;
        end
        check("fade_trace_errors", 32'(trace_err), 0);
        check("fade_overflow_count", 32'(ov_count), 1);
        check("fade_dc_max", 32'(dc_max), 10);
        check("pwm_top_duty5", 32'(hi5), 10);
        check("pwm_top_duty10", 32'(hi10), 26);
        check("pwm_top_duty0", 32'(lo0), 0);

        // standalone PWM: align on a rising edge, then change 5 -> 7 mid-period
        pw_duty = 4'd5;
        tick(25);
        found = 0;
        prev  = pwm_sa;
        for (int i = 0; i < 30 && found == 0; i++) begin
            tick(1);
            if (prev === 1'b0 && pwm_sa === 1'b1) found = 1;
            prev = pwm_sa;
        end
        check("pwm_rise_found", 32'(found), 1);
        got = '0;
        for (int k = 1; k <= 19; k++) begin
            tick(1);
            got = {got[17:0], pwm_sa};
            if (k == 2) pw_duty = 4'd7;
        end
        check("pwm_5_to_7", 32'(got), 32'(19'b1111000001111111000));

        pw_duty = 4'd0;
        tick(12);
        count_high(20, 1, cnt);
        check("pwm_duty0_low", 32'(cnt), 0);
        pw_duty = 4'd10;
        tick(12);
        count_high(20, 1, cnt);
        check("pwm_duty10_high", 32'(cnt), 20);
        pw_duty = 4'd15;
        tick(12);
        count_high(20, 1, cnt);
        check("pwm_duty15_high", 32'(cnt), 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_fade_engine.md
Name: led_fade_engine

Overview:
- Timing/brightness engine for the LED animation controller. It bundles three functions:
  - a retriggerable one-shot interval timer that paces the shift animations;
  - a duty-cycle ramp controller that fades brightness up, holds, and fades down;
  - a PWM waveform generator driven by that ramp.
- The animation sequencer consumes out_pulse, pwm_out, d_c and overflow.

Parameters:
- N, 6, width of timer load/count.
- T, 10, PWM period in clocks.
- T1, 40, clocks per duty step on the up-ramp.
- T2, 35, clocks per duty step on the down-ramp.
- K, 20, clocks the duty is held at peak.
- DMAX, 10, peak duty value (must be ≤ 15 and ≤ T).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset.
- timer_clr  in  1  synchronous clear of the timer only; active high.
- trig  in  1  timer arm/run request.
- load  in  N  timer interval in clocks.
- out_pulse  out  1  one-cycle pulse at timer expiry.
- start  in  1  begin one fade cycle.
- d_c  out  4  current duty value.
- overflow  out  1  one-cycle pulse at end of fade cycle.
- pwm_out  out  1  PWM waveform.

Behaviour:
- Reset (rst=0 at a clock edge):
  - timer goes to IDLE, internal count=0, out_pulse=0;
  - controller goes to IDLE, d_c=0, overflow=0;
  - PWM phase counter=0, latched duty=0, pwm_out=0.
- Reset has priority over every other input.
- Timer states:
  - IDLE -> COUNT when trig=1; count loads with load (load=0 is treated as 1).
  - COUNT decrements count each clock. If trig was sampled at edge E0, out_pulse=1 for exactly the one cycle following edge E0+load; the state then goes to DONE.
  - If trig=0 while in COUNT, the timer aborts to IDLE with no pulse.
  - DONE -> IDLE when trig=0. A trig held high never produces a second pulse.
  - timer_clr=1 forces IDLE with out_pulse=0 and has priority over trig.
- Controller states:
  - IDLE: d_c=0. start=1 sampled at edge E0 goes to UP with step counter=0. start is ignored outside IDLE.
  - UP: step counter runs 0..T1-1; on wrap d_c+=1. When d_c reaches DMAX the state goes to HOLD. So d_c=1 after E0+T1, and d_c=DMAX after E0+DMAX*T1.
  - HOLD: K clocks, then DOWN.
  - DOWN: every T2 clocks d_c-=1. On the edge where d_c becomes 0, overflow=1 for that single cycle and the state goes to IDLE.
  - With defaults, overflow occurs at E0+400+20+350 = E0+770.
  - If start=1 during the overflow cycle, a new cycle begins at the next edge.
- PWM:
  - Phase counter pc runs 0..T-1 and wraps.
  - Duty is latched from d_c when pc==T-1, so a new duty takes effect from the next period (glitch-free).
  - pwm_out is registered: pwm_out = (pc < latched duty).
  - Duty 0 gives constant low; duty ≥ T gives constant high.
- Arithmetic: all counters are unsigned and saturate-free within parameter ranges. d_c never exceeds DMAX or goes below 0.
- Simultaneous events: out_pulse and overflow are independent. Timer and controller do not interact internally. d_c is driven only by the controller.

Decomposition:
- Shared package contains:
  - default parameter constants (N, T, T1, T2, K, DMAX);
  - timer state enum {IDLE, COUNT, DONE};
  - controller state enum {IDLE, UP, HOLD, DOWN}.
- One natural sub-module: pwm_wave_gen (T, 4-bit duty in, pwm_out).
- Timer and controller FSMs stay in led_fade_engine.

Test Plan:
- Reset: hold rst=0 for 3 clocks with trig=1 and start=1 -> out_pulse, overflow, d_c and pwm_out are all 0. After release, the timer arms on the first edge.
- Timer, load=10, trig held high:
  - out_pulse is high for exactly one cycle, 10 clocks after arm, and never repeats while trig stays high;
  - drop trig for 1 clock, then raise it again -> a second pulse 10 clocks later.
- Timer abort and clear:
  - trig drops at count 5 -> no pulse;
  - timer_clr=1 mid-count with trig=1 -> no pulse, and re-arm occurs after timer_clr=0.
- Fade cycle: one-cycle start pulse ->
  - d_c steps 0→10 every 40 clocks;
  - holds 20 clocks;
  - steps 10→0 every 35 clocks;
  - overflow pulses once, at 770 clocks after start, coincident with d_c=0;
  - start pulses during UP are ignored.
- PWM: force d_c=5 steady -> pwm_out is 5 high / 5 low per 10 clocks.
  - A change to 7 mid-period takes effect only at the next period boundary.
  - d_c=0 gives constant low; d_c=10 gives constant high.
